param_serializer: RTL and testbench

Parametrised word-to-bitstream serializer for the audio output path. Accepts WIDTH-bit sample words from the address-creator/memory side over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Shifts each word out one bit per DIV clock cycles, MSB- or LSB-first, with no gap between consecutive words, and drives the audio pins (audio_enable, D12 data). It is the next generation of the 16-bit, one-bit-per-cycle audio serializer, adding a configurable rate, bit order, input buffering, flow control and underrun reporting.

---
 rtl/param_serializer.sv | 227 ++++++++++++++++++++++
 tb/tb_param_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/param_serializer.sv
// param_serializer
//
// Word-to-bitstream serializer for the audio output path. Sample words arrive
// over a valid/ready handshake and are buffered in a DEPTH-entry FIFO. Each
// word is shifted out one bit every DIV clocks, MSB- or LSB-first. Consecutive
// words follow each other with no gap on audio_data_o.
//
// Parameters:
//   WIDTH     bits per word (>= 2)
//   DEPTH     FIFO entries (power of 2, >= 2)
//   DIV       clocks each bit is held (>= 1)
//   MSB_FIRST 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports:
//   clock_i        single rising-edge clock
//   reset_i        asynchronous, active-high reset
//   enable_i       run/abort control; dropping it mid-word discards that word
//   in_data_i      word to enqueue
//   in_valid_i     in_data_i is valid this cycle
//   in_ready_o     FIFO not full (combinational)
//   audio_enable_o combinational copy of enable_i
//   audio_data_o   registered serial bit
//   word_done_o    one-cycle pulse at the edge that ends a word's last bit
//   underrun_o     one-cycle pulse when a word ends with the FIFO empty
//   bit_count_o    index of the bit currently on audio_data_o
//   fill_o         number of words held in the FIFO

module param_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned DIV       = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic                       audio_enable_o,
  output logic                       audio_data_o,
  output logic                       word_done_o,
  output logic                       underrun_o,
  output logic [$clog2(WIDTH)-1:0]   bit_count_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int unsigned BitW  = $clog2(WIDTH);
  localparam int unsigned FillW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  // A divide-by-1 still needs a one-bit counter so the logic stays uniform.
  localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [FillW-1:0] FillFull = FillW'(DEPTH);
  localparam logic [BitW-1:0]  LastBit  = BitW'(WIDTH - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(DIV - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             push;
  logic             pop;
  logic             fifo_nonempty;
  logic [WIDTH-1:0] head_word;

  assign in_ready_o    = (fill_q != FillFull);
  assign push          = in_valid_i && in_ready_o;
  assign fifo_nonempty = (fill_q != '0);
  assign head_word     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    // DEPTH is a power of two, so pointers wrap naturally.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + FillW'(1);
      2'b01:   fill_d = fill_q - FillW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset; only entries covered by fill_q are ever read.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             audio_q, audio_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             done_q, done_d;
  logic             under_q, under_d;
  logic [WIDTH-1:0] shift_next;
  logic             tick;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Shift register always presents the bit on the wire at its output end.
  assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_q[WIDTH-1:1]};
  assign tick       = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    audio_d = audio_q;
    bit_d   = bit_q;
    div_d   = div_q;
    done_d  = 1'b0;
    under_d = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        audio_d = 1'b0;
        bit_d   = '0;
        div_d   = '0;
        if (enable_i && fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head_word;
          audio_d = first_bit(head_word);
          state_d = StShift;
        end
      end

      StShift: begin
        if (!enable_i) begin
          // Abort: drop the partial word silently, FIFO untouched.
          state_d = StIdle;
          audio_d = 1'b0;
          bit_d   = '0;
          div_d   = '0;
        end else if (tick) begin
          div_d = '0;
          if (bit_q == LastBit) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (fifo_nonempty) begin
              // Gapless: next word's first bit lands on the same edge.
              pop     = 1'b1;
              shift_d = head_word;
              audio_d = first_bit(head_word);
            end else begin
              under_d = 1'b1;
              audio_d = 1'b0;
              state_d = StIdle;
            end
          end else begin
            shift_d = shift_next;
            audio_d = first_bit(shift_next);
            bit_d   = bit_q + BitW'(1);
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        audio_d = 1'b0;
        bit_d   = '0;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      shift_q <= '0;
      audio_q <= 1'b0;
      bit_q   <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      audio_q <= audio_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

  assign audio_enable_o = enable_i;
  assign audio_data_o   = audio_q;
  assign word_done_o    = done_q;
  assign underrun_o     = under_q;
  assign bit_count_o    = bit_q;
  assign fill_o         = fill_q;

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer: one instance at WIDTH=16/DIV=1/MSB-first,
// one at DIV=4/LSB-first, sharing clock and reset.

module tb_param_serializer;

  logic        clk;
  logic        rst;

  logic        a_en, a_valid, a_ready, a_aen, a_audio, a_done, a_under;
  logic [15:0] a_data;
  logic [3:0]  a_bc;
  logic [1:0]  a_fill;

  logic        b_en, b_valid, b_ready, b_aen, b_audio, b_done, b_under;
  logic [15:0] b_data;
  logic [3:0]  b_bc;
  logic [1:0]  b_fill;

  int n_checks = 0;
  int n_pass   = 0;

  param_serializer #(
    .WIDTH(16), .DEPTH(2), .DIV(1), .MSB_FIRST(1'b1)
  ) u_dut_a (
    .clock_i(clk), .reset_i(rst), .enable_i(a_en), .in_data_i(a_data),
    .in_valid_i(a_valid), .in_ready_o(a_ready), .audio_enable_o(a_aen),
    .audio_data_o(a_audio), .word_done_o(a_done), .underrun_o(a_under),
    .bit_count_o(a_bc), .fill_o(a_fill)
  );

  param_serializer #(
    .WIDTH(16), .DEPTH(2), .DIV(4), .MSB_FIRST(1'b0)
  ) u_dut_b (
    .clock_i(clk), .reset_i(rst), .enable_i(b_en), .in_data_i(b_data),
    .in_valid_i(b_valid), .in_ready_o(b_ready), .audio_enable_o(b_aen),
    .audio_data_o(b_audio), .word_done_o(b_done), .underrun_o(b_under),
    .bit_count_o(b_bc), .fill_o(b_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] w, w1, w2, w3, w4;

  initial begin
    rst = 1'b1;
    a_en = 1'b0; a_valid = 1'b0; a_data = '0;
    b_en = 1'b0; b_valid = 1'b0; b_data = '0;
    #12;
    check("rst_audio", 32'(a_audio), 32'd0);
    check("rst_done",  32'(a_done),  32'd0);
    check("rst_under", 32'(a_under), 32'd0);
    check("rst_bc",    32'(a_bc),    32'd0);
    check("rst_fill",  32'(a_fill),  32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_aen0",  32'(a_aen),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- single word A5C3, MSB first, DIV=1
    a_en = 1'b1;
    #1 check("aen1", 32'(a_aen), 32'd1);
    w = 16'hA5C3;
    a_data = w; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("t1_fill_push", 32'(a_fill), 32'd1);
    check("t1_idle_audio", 32'(a_audio), 32'd0);
    step();
    check("t1_fill_pop", 32'(a_fill), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("t1_bit", 32'(a_audio), 32'(w[15-i]));
      check("t1_bc", 32'(a_bc), 32'(i));
      check("t1_done_low", 32'(a_done), 32'd0);
      step();
    end
    check("t1_done", 32'(a_done), 32'd1);
    check("t1_under", 32'(a_under), 32'd1);
    check("t1_audio_end", 32'(a_audio), 32'd0);
    step();
    check("t1_done_1cyc", 32'(a_done), 32'd0);
    check("t1_under_1cyc", 32'(a_under), 32'd0);

    // ---- preload FFFF, 0000, then enable: gapless pair
    a_en = 1'b0;
    a_valid = 1'b1; a_data = 16'hFFFF;
    step();
    a_data = 16'h0000;
    step();
    a_valid = 1'b0;
    check("t2_fill2", 32'(a_fill), 32'd2);
    check("t2_ready0", 32'(a_ready), 32'd0);
    a_en = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      check("t2_bit", 32'(a_audio), 32'(i < 16));
      check("t2_done", 32'(a_done), 32'(i == 16));
      check("t2_under", 32'(a_under), 32'd0);
      step();
    end
    check("t2_done_end", 32'(a_done), 32'd1);
    check("t2_under_end", 32'(a_under), 32'd1);

    // ---- fill to full with enable low, third word waits for a pop
    a_en = 1'b0;
    w1 = 16'hB6D9; w2 = 16'h00FF; w3 = 16'hF0F0;
    a_valid = 1'b1; a_data = w1;
    step();
    check("t3_fill1", 32'(a_fill), 32'd1);
    a_data = w2;
    step();
    check("t3_fill2", 32'(a_fill), 32'd2);
    check("t3_ready0", 32'(a_ready), 32'd0);
    a_data = w3;
    step();
    check("t3_fill_held", 32'(a_fill), 32'd2);
    a_en = 1'b1;
    step();
    check("t3_fill_pop", 32'(a_fill), 32'd1);
    check("t3_ready1", 32'(a_ready), 32'd1);
    check("t3_w1_b0", 32'(a_audio), 32'(w1[15]));
    step();
    a_valid = 1'b0;
    check("t3_fill_w3", 32'(a_fill), 32'd2);
    check("t3_bc1", 32'(a_bc), 32'd1);
    repeat (6) step();
    check("t4_bc7", 32'(a_bc), 32'd7);
    check("t4_bit7", 32'(a_audio), 32'(w1[8]));

    // ---- abort at bit 7
    a_en = 1'b0;
    step();
    check("t4_abort_audio", 32'(a_audio), 32'd0);
    check("t4_abort_bc", 32'(a_bc), 32'd0);
    check("t4_abort_fill", 32'(a_fill), 32'd2);
    check("t4_abort_done", 32'(a_done), 32'd0);
    check("t4_abort_under", 32'(a_under), 32'd0);
    a_en = 1'b1;
    step();
    check("t4_w2_b0", 32'(a_audio), 32'(w2[15]));
    check("t4_w2_bc", 32'(a_bc), 32'd0);
    check("t4_w2_fill", 32'(a_fill), 32'd1);
    for (int i = 1; i < 16; i++) begin
      step();
      check("t4_w2_bit", 32'(a_audio), 32'(w2[15-i]));
    end
    step();
    check("t4_w2_done", 32'(a_done), 32'd1);
    check("t4_w2_nounder", 32'(a_under), 32'd0);
    check("t4_w3_b0", 32'(a_audio), 32'(w3[15]));
    check("t4_w3_bc", 32'(a_bc), 32'd0);
    check("t4_w3_fill", 32'(a_fill), 32'd0);

    // ---- async reset mid-word with fill = 1
    w4 = 16'h1357;
    a_valid = 1'b1; a_data = w4;
    step();
    a_valid = 1'b0;
    check("t5_fill1", 32'(a_fill), 32'd1);
    step();
    step();
    check("t5_bc3", 32'(a_bc), 32'd3);
    check("t5_bit3", 32'(a_audio), 32'(w3[12]));
    rst = 1'b1;
    #1;
    check("t5_rst_fill", 32'(a_fill), 32'd0);
    check("t5_rst_audio", 32'(a_audio), 32'd0);
    check("t5_rst_bc", 32'(a_bc), 32'd0);
    check("t5_rst_ready", 32'(a_ready), 32'd1);
    check("t5_rst_done", 32'(a_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    w = 16'h8001;
    a_valid = 1'b1; a_data = w;
    step();
    a_valid = 1'b0;
    check("t5_lat_idle", 32'(a_audio), 32'd0);
    step();
    check("t5_lat_bit", 32'(a_audio), 32'(w[15]));
    check("t5_lat_bc", 32'(a_bc), 32'd0);
    a_en = 1'b0;
    step();

    // ---- DIV=4, LSB first, word 0001
    b_en = 1'b1;
    b_data = 16'h0001; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    for (int i = 0; i < 64; i++) begin
      check("t6_bit", 32'(b_audio), 32'(i < 4));
      check("t6_bc", 32'(b_bc), 32'(i / 4));
      check("t6_done_low", 32'(b_done), 32'd0);
      step();
    end
    check("t6_done", 32'(b_done), 32'd1);
    check("t6_under", 32'(b_under), 32'd1);
    check("t6_audio_end", 32'(b_audio), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
